dff_bank_arbiter: RTL and testbench

Round-robin write arbiter sharing one WIDTH-bit D-flip-flop register bank between NREQ requesters. Each cycle it picks at most one requester, loads that requester's data into the shared register, and reports the winner. A requester may lock the register for a bounded burst. The block sits in front of the register bank and is the only writer to it.

---
 rtl/dff_bank_arbiter.sv | 137 +++++++++++++
 tb/tb_dff_bank_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/dff_bank_arbiter.sv
// Round-robin write arbiter in front of one shared WIDTH-bit register.
// Each cycle it picks at most one requester, loads that requester's data
// and reports the winner. A requester may hold the register for a burst
// of up to MAX_LOCK beats.
// Ports: clk, reset (sync, active-high), req/lock (NREQ), wdata (NREQ*WIDTH)
//        -> gnt (one-hot), q (shared register), valid, owner, lock_expired.
module dff_bank_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_LOCK = 16,
    parameter int OW       = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       lock,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      q,
    output logic                  valid,
    output logic [OW-1:0]         owner,
    output logic                  lock_expired
);

    localparam int LW = $clog2(MAX_LOCK) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SINGLE,
        LOCKED
    } state_t;

    state_t            state_q, state_d;
    logic [OW-1:0]     ptr_q, ptr_d;
    logic [LW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              valid_q, valid_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic              exp_q, exp_d;

    logic              found;
    logic [OW-1:0]     win;
    int                idx;

    // First requesting index scanning ptr, ptr+1, ... modulo NREQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = OW'(idx);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            owner_q <= '0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            owner_q <= owner_d;
            exp_q   <= exp_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        gnt_d   = '0;
        valid_d = 1'b0;
        owner_d = owner_q;
        exp_d   = 1'b0;
        if (state_q == LOCKED) begin
            // Only the owner is looked at; ptr already points past it.
            if (req[owner_q]) begin
                data_d  = wdata[int'(owner_q)*WIDTH +: WIDTH];
                gnt_d   = gnt_q;
                valid_d = 1'b1;
                if (lock[owner_q] && cnt_q < LW'(MAX_LOCK - 1)) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    exp_d   = lock[owner_q];
                    state_d = SINGLE;
                    cnt_d   = '0;
                end
            end else begin
                // Voluntary release costs one idle cycle.
                state_d = IDLE;
                cnt_d   = '0;
            end
        end else if (found) begin
            data_d     = wdata[int'(win)*WIDTH +: WIDTH];
            gnt_d[win] = 1'b1;
            valid_d    = 1'b1;
            owner_d    = win;
            ptr_d      = OW'((int'(win) + 1) % NREQ);
            if (lock[win]) begin
                state_d = LOCKED;
                cnt_d   = LW'(1);
            end else begin
                state_d = SINGLE;
            end
        end else begin
            state_d = IDLE;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        gnt          = gnt_q;
        q            = data_q;
        valid        = valid_q;
        owner        = owner_q;
        lock_expired = exp_q;
    end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter (NREQ=4, WIDTH=8, MAX_LOCK=4).
// Expected values are hand-computed per scenario.
module tb_dff_bank_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        valid;
    logic [1:0]  owner;
    logic        lock_expired;

    int errs;
    int checks;

    dff_bank_arbiter #(
        .NREQ(4),
        .WIDTH(8),
        .MAX_LOCK(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .lock(lock),
        .wdata(wdata),
        .gnt(gnt),
        .q(q),
        .valid(valid),
        .owner(owner),
        .lock_expired(lock_expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g,
                              input logic [7:0] d, input logic v,
                              input logic [1:0] o, input logic le);
        chk({tag, ".gnt"}, 32'(gnt), 32'(g));
        chk({tag, ".q"}, 32'(q), 32'(d));
        chk({tag, ".valid"}, 32'(valid), 32'(v));
        chk({tag, ".owner"}, 32'(owner), 32'(o));
        chk({tag, ".lexp"}, 32'(lock_expired), 32'(le));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wd(input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
        wdata = {d3, d2, d1, d0};
    endtask

    initial begin
        errs   = 0;
        checks = 0;
        reset  = 1'b1;
        req    = 4'b1111;
        lock   = 4'b0000;
        set_wd(8'h10, 8'h11, 8'h12, 8'h13);

        // Reset with all requests high
        repeat (3) step();
        expect_out("rst", 4'b0000, 8'h00, 1'b0, 2'd0, 1'b0);

        // Rotation 0,1,2,3,0
        reset = 1'b0;
        step(); expect_out("rr0", 4'b0001, 8'h10, 1'b1, 2'd0, 1'b0);
        step(); expect_out("rr1", 4'b0010, 8'h11, 1'b1, 2'd1, 1'b0);
        step(); expect_out("rr2", 4'b0100, 8'h12, 1'b1, 2'd2, 1'b0);
        step(); expect_out("rr3", 4'b1000, 8'h13, 1'b1, 2'd3, 1'b0);
        step(); expect_out("rr4", 4'b0001, 8'h10, 1'b1, 2'd0, 1'b0);

        // Grant to 1 (ptr=2), then skip with req=0011
        step(); expect_out("sk1", 4'b0010, 8'h11, 1'b1, 2'd1, 1'b0);
        req = 4'b0011;
        step(); expect_out("sk2", 4'b0001, 8'h10, 1'b1, 2'd0, 1'b0);
        step(); expect_out("sk3", 4'b0010, 8'h11, 1'b1, 2'd1, 1'b0);
        step(); expect_out("sk4", 4'b0001, 8'h10, 1'b1, 2'd0, 1'b0);

        // Move ptr to 2
        req = 4'b0010;
        step(); expect_out("pre", 4'b0010, 8'h11, 1'b1, 2'd1, 1'b0);

        // Locked burst by 2, lock dropped on 3rd beat
        req  = 4'b1111;
        lock = 4'b0100;
        set_wd(8'h10, 8'h11, 8'hA0, 8'h13);
        step(); expect_out("lb1", 4'b0100, 8'hA0, 1'b1, 2'd2, 1'b0);
        set_wd(8'h10, 8'h11, 8'hA1, 8'h13);
        step(); expect_out("lb2", 4'b0100, 8'hA1, 1'b1, 2'd2, 1'b0);
        lock = 4'b0000;
        set_wd(8'h10, 8'h11, 8'hA2, 8'h13);
        step(); expect_out("lb3", 4'b0100, 8'hA2, 1'b1, 2'd2, 1'b0);
        step(); expect_out("lb4", 4'b1000, 8'h13, 1'b1, 2'd3, 1'b0);

        // Lock expiry: requester 1 locks, 0 waiting (ptr=0 now)
        req  = 4'b0010;
        lock = 4'b0010;
        set_wd(8'h10, 8'h21, 8'h12, 8'h13);
        step(); expect_out("le1", 4'b0010, 8'h21, 1'b1, 2'd1, 1'b0);
        req = 4'b0011;
        set_wd(8'h10, 8'h22, 8'h12, 8'h13);
        step(); expect_out("le2", 4'b0010, 8'h22, 1'b1, 2'd1, 1'b0);
        set_wd(8'h10, 8'h23, 8'h12, 8'h13);
        step(); expect_out("le3", 4'b0010, 8'h23, 1'b1, 2'd1, 1'b0);
        set_wd(8'h10, 8'h24, 8'h12, 8'h13);
        step(); expect_out("le4", 4'b0010, 8'h24, 1'b1, 2'd1, 1'b1);
        step(); expect_out("le5", 4'b0001, 8'h10, 1'b1, 2'd0, 1'b0);

        // Release bubble (ptr=1)
        req  = 4'b1111;
        lock = 4'b0010;
        set_wd(8'h10, 8'h31, 8'h12, 8'h13);
        step(); expect_out("rb1", 4'b0010, 8'h31, 1'b1, 2'd1, 1'b0);
        req  = 4'b1101;
        lock = 4'b0000;
        step(); expect_out("rb2", 4'b0000, 8'h31, 1'b0, 2'd1, 1'b0);
        step(); expect_out("rb3", 4'b0100, 8'h12, 1'b1, 2'd2, 1'b0);

        // Mid-burst reset (ptr=3; requester 1 locks, ptr->2)
        req  = 4'b0010;
        lock = 4'b0010;
        set_wd(8'h10, 8'h54, 8'h12, 8'h13);
        step(); expect_out("mr1", 4'b0010, 8'h54, 1'b1, 2'd1, 1'b0);
        req = 4'b1111;
        set_wd(8'h10, 8'h55, 8'h12, 8'h13);
        step(); expect_out("mr2", 4'b0010, 8'h55, 1'b1, 2'd1, 1'b0);
        reset = 1'b1;
        step(); expect_out("mr3", 4'b0000, 8'h00, 1'b0, 2'd0, 1'b0);
        reset = 1'b0;
        lock  = 4'b0000;
        step(); expect_out("mr4", 4'b0001, 8'h10, 1'b1, 2'd0, 1'b0);
        step(); expect_out("mr5", 4'b0010, 8'h55, 1'b1, 2'd1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
